hazard_scoreboard: RTL

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 132 +++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: operand-forwarding select and ID-stage stall generation.
//   A combinational forwarding mux select is produced per read port. A
//   registered pending-write bitmap tracks outstanding long-latency
//   (div/mul) destinations. A saturating counter records the number of
//   stalled ID cycles.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   st_we_i/st_waddr_i/st_ready_i  per forwarding stage (0=EX,1=MEM,2=WB)
//   rd_re_i/rd_addr_i         per read port enable/address
//   id_valid_i/id_we_i/id_long_i/id_waddr_i  instruction in ID
//   long_done_i/long_done_waddr_i  long-latency unit completion
//   perf_clr_i                clear stall counter
//   fwd_sel_o                 per port: 0=regfile, s+1=forward from stage s
//   stall_o, long_cnt_o, stall_cnt_o

// Per read port: youngest-hit forwarding select and hazard flags.
module hazard_rport #(
  parameter int NUM_STAGES = 3,
  parameter int ADDR_W     = 5,
  parameter int SEL_W      = 2
) (
  input  logic                         rd_re,
  input  logic [ADDR_W-1:0]            rd_addr,
  input  logic [NUM_STAGES-1:0]        st_we,
  input  logic [NUM_STAGES*ADDR_W-1:0] st_waddr,
  input  logic [NUM_STAGES-1:0]        st_ready,
  input  logic [(1<<ADDR_W)-1:0]       pend,
  output logic [SEL_W-1:0]             fwd_sel,
  output logic                         load_use,
  output logic                         raw_long
);
  // Walk oldest to youngest so the youngest hit is assigned last and wins.
  always_comb begin
    fwd_sel  = '0;
    load_use = 1'b0;
    for (int s = NUM_STAGES-1; s >= 0; s--) begin
      if (rd_re && (rd_addr != '0) && st_we[s] &&
          (st_waddr[s*ADDR_W +: ADDR_W] == rd_addr)) begin
        fwd_sel  = SEL_W'(s + 1);
        load_use = !st_ready[s];
      end
    end
  end

  // pend[0] can never be set, so register 0 never reports a RAW hazard.
  assign raw_long = rd_re && pend[rd_addr];
endmodule

module hazard_scoreboard #(
  parameter  int NUM_RPORTS = 2,
  parameter  int NUM_STAGES = 3,
  parameter  int ADDR_W     = 5,
  parameter  int MAX_LONG   = 4,
  localparam int SEL_W      = $clog2(NUM_STAGES+1),
  localparam int CNT_W      = $clog2(MAX_LONG+1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_STAGES-1:0]        st_we_i,
  input  logic [NUM_STAGES*ADDR_W-1:0] st_waddr_i,
  input  logic [NUM_STAGES-1:0]        st_ready_i,
  input  logic [NUM_RPORTS-1:0]        rd_re_i,
  input  logic [NUM_RPORTS*ADDR_W-1:0] rd_addr_i,
  input  logic                         id_valid_i,
  input  logic                         id_we_i,
  input  logic                         id_long_i,
  input  logic [ADDR_W-1:0]            id_waddr_i,
  input  logic                         long_done_i,
  input  logic [ADDR_W-1:0]            long_done_waddr_i,
  input  logic                         perf_clr_i,
  output logic [NUM_RPORTS*SEL_W-1:0]  fwd_sel_o,
  output logic                         stall_o,
  output logic [CNT_W-1:0]             long_cnt_o,
  output logic [31:0]                  stall_cnt_o
);
  localparam int NREGS = 1 << ADDR_W;

  logic [NREGS-1:0]      pend;
  logic [NUM_RPORTS-1:0] load_use, raw_long;
  logic                  waw, full, issue, done_ok;

  for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_rport
    hazard_rport #(
      .NUM_STAGES (NUM_STAGES),
      .ADDR_W     (ADDR_W),
      .SEL_W      (SEL_W)
    ) u_rport (
      .rd_re    (rd_re_i[p]),
      .rd_addr  (rd_addr_i[p*ADDR_W +: ADDR_W]),
      .st_we    (st_we_i),
      .st_waddr (st_waddr_i),
      .st_ready (st_ready_i),
      .pend     (pend),
      .fwd_sel  (fwd_sel_o[p*SEL_W +: SEL_W]),
      .load_use (load_use[p]),
      .raw_long (raw_long[p])
    );
  end

  // All hazards are judged against registered state: a completion only
  // releases dependents on the cycle after long_done_i.
  assign waw     = id_we_i && pend[id_waddr_i];
  assign full    = id_long_i && (long_cnt_o == CNT_W'(MAX_LONG));
  assign stall_o = id_valid_i && (|load_use || |raw_long || waw || full);

  assign issue   = id_valid_i && !stall_o && id_long_i && id_we_i &&
                   (id_waddr_i != '0);
  assign done_ok = long_done_i && (long_cnt_o != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      pend       <= '0;
      long_cnt_o <= '0;
    end else begin
      // Clear first, then set: a same-register issue overrides completion.
      if (done_ok) pend[long_done_waddr_i] <= 1'b0;
      if (issue)   pend[id_waddr_i]        <= 1'b1;
      case ({issue, done_ok})
        2'b10:   long_cnt_o <= long_cnt_o + CNT_W'(1);
        2'b01:   long_cnt_o <= long_cnt_o - CNT_W'(1);
        default: long_cnt_o <= long_cnt_o;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || perf_clr_i)
      stall_cnt_o <= '0;
    else if (stall_o && (stall_cnt_o != 32'hFFFF_FFFF))
      stall_cnt_o <= stall_cnt_o + 32'd1;
  end
endmodule
